// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, MSB first, with
// valid/ready handshakes. Optional early exit under SEQ_DIVIDER_EARLY_EXIT_EN.
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    // Dividend bits leave from the top while quotient bits enter at the bottom.
    logic [DW-1:0] work_q, work_d;
    logic [VW-1:0] divisor_q, divisor_d;
    logic [VW:0]   prem_q, prem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;

    logic [VW+1:0] shifted;
    logic [VW+1:0] trial;
    logic          q_bit;
    logic          accept;
    logic          consume;
    logic          early;

    assign accept  = in_valid & in_ready_q;
    assign consume = out_valid_q & out_ready;

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    assign early = (dividend < DW'(divisor));
`else
    assign early = 1'b0;
`endif

    // Top bit of shifted is always zero, so trial[VW+1] acts as the borrow.
    assign shifted = {prem_q, work_q[DW-1]};
    assign trial   = shifted - {2'b00, divisor_q};
    assign q_bit   = ~trial[VW+1];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d   = state_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        prem_d    = prem_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d    = dividend;
                    divisor_d = divisor;
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = '1;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else if (early) begin
                        quot_d  = '0;
                        rem_d   = dividend[VW-1:0];
                        dbz_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        prem_d  = '0;
                        cnt_d   = CW'(DW - 1);
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                prem_d = q_bit ? trial[VW:0] : shifted[VW:0];
                work_d = (work_q << 1) | DW'(q_bit);
                if (cnt_q == '0) begin
                    quot_d  = work_d;
                    rem_d   = prem_d[VW-1:0];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (consume) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The result is presented one cycle after DONE is entered, and drops on the consuming edge.
    assign out_valid_d = (state_q == DONE) & ~consume;
    assign in_ready_d  = (state_d == IDLE);

    // NOTE: there is no storage array here, so every register takes a defined reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            divisor_q   <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            work_q      <= work_d;
            divisor_q   <= divisor_d;
            prem_q      <= prem_d;
            cnt_q       <= cnt_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboarded bench for seq_divider: directed cases, full operand sweep and
// random back-pressure, against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_divider;

    localparam int DW = 8;
    localparam int VW = 4;
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    logic or_fixed = 1'b1;
    logic bp_en    = 1'b0;
    logic bp_rand  = 1'b1;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    assign out_ready = bp_en ? bp_rand : or_fixed;

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int unsigned a, input int unsigned b);
        exp_t e;
        if (b == 0) begin
            e.q = '1;
            e.r = '1;
            e.z = 1'b1;
        end else begin
            e.q = DW'(a / b);
            e.r = VW'(a % b);
            e.z = 1'b0;
        end
        return e;
    endfunction

    function automatic int exp_latency(input int unsigned a, input int unsigned b);
        if (b == 0 || (EARLY && a < b)) return 1;
        return DW + 1;
    endfunction

    // Monitor: compare every presented result against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                check("result_pending", longint'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb[0];
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("div_by_zero", div_by_zero, e.z);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            bp_rand = 1'($urandom_range(0, 1));
        end
    end

    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit wait_result);
        int guard;
        int lat;
        bit busy_ok;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1);
            return;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
        check("in_ready_low_after_accept", in_ready, 0);
        if (!wait_result) return;
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_latency(a, b));
        check("in_ready_while_busy", busy_ok, 1);
        if (!bp_en && or_fixed) begin
            @(posedge clk);
            #1;
            check("in_ready_after_consume", in_ready, 1);
            check("out_valid_after_consume", out_valid, 0);
        end
    endtask

    initial begin
        int n_seen;
        int guard;
        logic [DW-1:0] ra;
        logic [VW-1:0] rb;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_div_by_zero", div_by_zero, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(8'd225, 4'd15, 1'b1);
        issue(8'd200, 4'd7, 1'b1);
        issue(8'd255, 4'd1, 1'b1);
        issue(8'd13, 4'd0, 1'b1);
        issue(8'd9, 4'd3, 1'b1);

        // Stalled consumer with in_valid pulses that must be ignored.
        or_fixed = 1'b0;
        issue(8'd100, 4'd9, 1'b1);
        repeat (5) begin
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            in_valid = 1'b1;
            dividend = 8'd77;
            divisor  = 4'd2;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("hold_out_valid_end", out_valid, 1);
        or_fixed = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);
        check("release_drained", sb.size(), 0);

        // Abort mid-RUN.
        issue(8'd150, 4'd6, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_div_by_zero", div_by_zero, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid) n_seen++;
        end
        check("no_result_after_abort", n_seen, 0);
        issue(8'd150, 4'd6, 1'b1);

        issue(8'd3, 4'd9, 1'b1);

        for (int a = 0; a < (1 << DW); a++)
            for (int b = 0; b < (1 << VW); b++)
                issue(DW'(a), VW'(b), 1'b1);

        bp_en = 1'b1;
        repeat (200) begin
            ra = DW'($urandom);
            rb = VW'($urandom);
            issue(ra, rb, 1'b1);
        end
        bp_en = 1'b0;
        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("final_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish, %0d compared / %0d mismatched so far", n_cmp, n_fail);
        $fatal(1, "global timeout");
    end

endmodule
